kmac_right_decode: RTL and testbench

Decodes a NIST SP 800-185 right_encode byte string, O1..On || enc8(n), back into an integer for the KMAC datapath. Bytes arrive serially over a valid/ready stream with a last flag. The block accumulates the O bytes and takes the final byte as n. It checks the encoding and presents value, byte count and error status over a valid/ready result handshake. It serves as the checker/parser counterpart of the right-pad/right-encode generator, used on received tags and by the verification model.

---
 rtl/kmac_pkg.sv | 19 +
 rtl/kmac_right_decode.sv | 121 ++++++++++++
 tb/tb_kmac_right_decode.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/kmac_pkg.sv
// Shared types for the KMAC right_encode decoder (state and error codes).
package kmac_pkg;

    localparam int ENC_BYTE_W = 8;

    typedef enum logic [0:0] {
        RECV   = 1'b0,
        RESULT = 1'b1
    } rdec_state_t;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_ZERO_LEN     = 3'd1,
        ERR_TOO_LONG     = 3'd2,
        ERR_LEN_MISMATCH = 3'd3,
        ERR_NON_MINIMAL  = 3'd4
    } rdec_err_t;

endpackage

// File: rtl/kmac_right_decode.sv
// right_encode decoder: shifts in O1..On (MSB first), treats the last byte as n,
// validates the encoding and holds the result until the consumer takes it.
// Optional KMAC_RDEC_STRICT_EN: reject encodings with a leading zero byte (n>1).
module kmac_right_decode
    import kmac_pkg::*;
#(
    parameter int MAX_BYTES = 8,
    parameter int VALUE_W   = 8 * MAX_BYTES,
    parameter int CNT_W     = $clog2(MAX_BYTES + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ENC_BYTE_W-1:0] in_byte,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VALUE_W-1:0]    value,
    output logic [CNT_W-1:0]      nbytes,
    output rdec_err_t             err_code
);

    localparam int NB_SAT = (1 << CNT_W) - 1;

    rdec_state_t           state, state_nxt;
    logic [VALUE_W-1:0]    acc, acc_shift;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf;
    logic                  take;
    rdec_err_t             err_nxt;
`ifdef KMAC_RDEC_STRICT_EN
    logic [ENC_BYTE_W-1:0] first_byte;
`endif

    assign take = in_valid && in_ready;

    // Narrowest configuration holds a single byte, so there is nothing to shift.
    if (VALUE_W > ENC_BYTE_W) begin : g_shift
        assign acc_shift = {acc[VALUE_W-ENC_BYTE_W-1:0], in_byte};
    end else begin : g_noshift
        assign acc_shift = in_byte;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RECV;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; in_ready is held low during reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            RECV: begin
                in_ready = rst_n;
                if (take && in_last) state_nxt = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = RECV;
            end
            default: state_nxt = RECV;
        endcase
    end

    // Encoding check against the incoming length byte; earliest rule wins.
    always_comb begin
        err_nxt = ERR_NONE;
        if (in_byte == '0)
            err_nxt = ERR_ZERO_LEN;
        else if (in_byte > ENC_BYTE_W'(MAX_BYTES) || ovf)
            err_nxt = ERR_TOO_LONG;
        else if (ENC_BYTE_W'(cnt) != in_byte)
            err_nxt = ERR_LEN_MISMATCH;
`ifdef KMAC_RDEC_STRICT_EN
        else if (in_byte > ENC_BYTE_W'(1) && first_byte == '0)
            err_nxt = ERR_NON_MINIMAL;
`endif
    end

    // Accumulator, byte counter and registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            value    <= '0;
            nbytes   <= '0;
            err_code <= ERR_NONE;
`ifdef KMAC_RDEC_STRICT_EN
            first_byte <= '0;
`endif
        end else if (take) begin
            if (!in_last) begin
                acc <= acc_shift;
                // Past MAX_BYTES the count sticks; ovf marks the result as unusable.
                if (cnt == CNT_W'(MAX_BYTES)) ovf <= 1'b1;
                else                          cnt <= cnt + CNT_W'(1);
`ifdef KMAC_RDEC_STRICT_EN
                if (cnt == '0) first_byte <= in_byte;
`endif
            end else begin
                value    <= (err_nxt == ERR_NONE) ? acc : '0;
                nbytes   <= (in_byte > ENC_BYTE_W'(NB_SAT)) ? CNT_W'(NB_SAT)
                                                             : in_byte[CNT_W-1:0];
                err_code <= err_nxt;
            end
        end else if (state == RESULT && out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
`ifdef KMAC_RDEC_STRICT_EN
            first_byte <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_kmac_right_decode.sv
// Self-checking bench for kmac_right_decode (MAX_BYTES=8).
module tb_kmac_right_decode;
    import kmac_pkg::*;

    localparam int MAXB = 8;
    localparam int VW   = 8 * MAXB;
    localparam int CW   = $clog2(MAXB + 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_byte = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] value;
    logic [CW-1:0] nbytes;
    rdec_err_t     err_code;

    typedef struct {
        logic [VW-1:0] value;
        logic [CW-1:0] nbytes;
        logic [2:0]    err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] sbuf[0:15];
    int         n_tests = 0;
    int         n_fail  = 0;

    kmac_right_decode #(.MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .value(value), .nbytes(nbytes), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Present one byte from a negedge and hold it until the DUT takes it.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_byte = b; in_last = last;
        while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (in_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Push the expected result, then stream sbuf[0..len-1] with last on the final byte.
    task automatic send_stream(input int len, input logic [VW-1:0] ev,
                               input logic [CW-1:0] en, input logic [2:0] ee);
        exp_t e;
        e.value = ev; e.nbytes = en; e.err = ee;
        sb.push_back(e);
        for (int i = 0; i < len; i++) send_byte(sbuf[i], i == len - 1);
    endtask

    // Wait (bounded) for a result, compare against the scoreboard head, then accept it.
    task automatic get_result(input string name);
        exp_t e;
        int t;
        t = 0;
        while (out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        n_tests++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_result: out_valid=%b queued=%0d required valid result",
                     name, out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        if (value !== e.value) begin
            n_fail++; $display("FAIL %s_value: got %h required %h", name, value, e.value);
        end
        n_tests++;
        if (nbytes !== e.nbytes) begin
            n_fail++; $display("FAIL %s_nbytes: got %0d required %0d", name, nbytes, e.nbytes);
        end
        n_tests++;
        if (err_code !== e.err) begin
            n_fail++; $display("FAIL %s_err: got %0d required %0d", name, err_code, e.err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || value !== '0 || nbytes !== '0 ||
            err_code !== ERR_NONE) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b val=%h nb=%0d err=%0d required 0,0,0,0,0",
                     in_ready, out_valid, value, nbytes, err_code);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        sbuf[0] = 8'h01; sbuf[1] = 8'h00; sbuf[2] = 8'h02;
        send_stream(3, 64'h100, 4'd2, ERR_NONE);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_latency: out_valid=%b required 1", out_valid);
        end
        get_result("basic");
        sbuf[0] = 8'h00; sbuf[1] = 8'h01;
        send_stream(2, 64'h0, 4'd1, ERR_NONE);
        get_result("enc_zero");
        sbuf[0] = 8'h01; sbuf[1] = 8'h02; sbuf[2] = 8'h03; sbuf[3] = 8'h04;
        sbuf[4] = 8'h05; sbuf[5] = 8'h06; sbuf[6] = 8'h07; sbuf[7] = 8'h08; sbuf[8] = 8'h08;
        send_stream(9, 64'h0102030405060708, 4'd8, ERR_NONE);
        get_result("max_len");
    endtask

    task automatic test_errors();
        sbuf[0] = 8'h00;
        send_stream(1, 64'h0, 4'd0, ERR_ZERO_LEN);
        get_result("zero_len");
        sbuf[0] = 8'hAB; sbuf[1] = 8'h03;
        send_stream(2, 64'h0, 4'd3, ERR_LEN_MISMATCH);
        get_result("mismatch");
        for (int i = 0; i < 9; i++) sbuf[i] = 8'hFF;
        sbuf[9] = 8'h09;
        send_stream(10, 64'h0, 4'd9, ERR_TOO_LONG);
        get_result("too_long");
        sbuf[0] = 8'h20;
        send_stream(1, 64'h0, 4'd15, ERR_TOO_LONG);
        get_result("lone_big");
        sbuf[0] = 8'h03;
        send_stream(1, 64'h0, 4'd3, ERR_LEN_MISMATCH);
        get_result("lone_mid");
    endtask

    task automatic test_non_minimal();
        sbuf[0] = 8'h00; sbuf[1] = 8'h05; sbuf[2] = 8'h02;
`ifdef KMAC_RDEC_STRICT_EN
        send_stream(3, 64'h0, 4'd2, ERR_NON_MINIMAL);
`else
        send_stream(3, 64'h5, 4'd2, ERR_NONE);
`endif
        get_result("non_minimal");
    endtask

    task automatic test_hold();
        sbuf[0] = 8'h12; sbuf[1] = 8'h34; sbuf[2] = 8'h02;
        send_stream(3, 64'h1234, 4'd2, ERR_NONE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_byte = 8'($urandom); in_last = 1'b1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || value !== 64'h1234 ||
                nbytes !== 4'd2 || err_code !== ERR_NONE) begin
                n_fail++;
                $display("FAIL hold_stable: vld=%b rdy=%b val=%h nb=%0d err=%0d required 1,0,1234,2,0",
                         out_valid, in_ready, value, nbytes, err_code);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        get_result("hold");
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: rdy=%b vld=%b required 1,0", in_ready, out_valid);
        end
        sbuf[0] = 8'h7F; sbuf[1] = 8'h01;
        send_stream(2, 64'h7F, 4'd1, ERR_NONE);
        get_result("after_hold");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ready: got %b required 0", in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: vld=%b rdy=%b required 0,0", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sbuf[0] = 8'h2A; sbuf[1] = 8'h01;
        send_stream(2, 64'h2A, 4'd1, ERR_NONE);
        get_result("after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_non_minimal();
        test_hold();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: queued=%0d out_valid=%b required 0,0", sb.size(), out_valid);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
